// File: rtl/icache_filler_if.sv
// Handshake/bus bundle between the instruction-cache filler and its fetch unit, RAM arbiter and cache.
// master = filler side (drives RAM address and cache write), slave = environment side.
interface icache_filler_if #(
  parameter int BLOCK_BYTES = 16
);
  logic                     req_valid;
  logic [31:0]              req_addr;
  logic                     mem_gnt;
  logic                     flush;
  logic [7:0]               mem_din;
  logic                     mem_req;
  logic [31:0]              mem_a;
  logic                     mem_wr;
  logic                     busy;
  logic                     we;
  logic [31:0]              fill_addr;
  logic [8*BLOCK_BYTES-1:0] block;

  modport master (
    input  req_valid, req_addr, mem_gnt, flush, mem_din,
    output mem_req, mem_a, mem_wr, busy, we, fill_addr, block
  );

  modport slave (
    output req_valid, req_addr, mem_gnt, flush, mem_din,
    input  mem_req, mem_a, mem_wr, busy, we, fill_addr, block
  );
endinterface

// File: rtl/icache_filler.sv
// Fills one cache block byte-by-byte from RAM; we pulses BLOCK_BYTES+2 cycles after accept; rdy_in=0 freezes all.
// Optional ICACHE_FILLER_ABORT_EN: flush during FETCH abandons the fill without a we pulse.
module icache_filler #(
  parameter int BLOCK_BYTES = 16
) (
  input  logic           clk_in,
  input  logic           rst_in,
  input  logic           rdy_in,
  icache_filler_if.master bus
);
  localparam int               OFF_W    = $clog2(BLOCK_BYTES);
  localparam int               CNT_W    = OFF_W + 1;
  localparam logic [31:0]      OFF_MASK = 32'(BLOCK_BYTES - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLOCK_BYTES);

  typedef enum logic [1:0] {IDLE, FETCH, COMMIT} state_e;

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [31:0]              base_q, base_d;
  logic [31:0]              fill_addr_q, fill_addr_d;
  logic [8*BLOCK_BYTES-1:0] block_q, block_d;
  logic [CNT_W-1:0]         byte_sel;
  logic                     abort;
  logic                     mem_req;
  logic                     we;
  logic [31:0]              mem_a;

`ifdef ICACHE_FILLER_ABORT_EN
  assign abort = bus.flush;
`else
  assign abort = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    base_d      = base_q;
    fill_addr_d = fill_addr_q;
    block_d     = block_q;
    byte_sel    = cnt_q - CNT_W'(1);
    mem_req     = 1'b0;
    mem_a       = '0;
    we          = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rdy_in && bus.req_valid && bus.mem_gnt) begin
          base_d  = bus.req_addr & ~OFF_MASK;
          cnt_d   = '0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        mem_req = 1'b1;
        // Past the last byte the address parks on the block's final byte.
        mem_a   = (cnt_q < CNT_LAST) ? base_q + 32'(cnt_q) : base_q + OFF_MASK;
        if (rdy_in) begin
          if (abort) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
            // RAM data lags the address by one cycle, so it belongs to byte cnt-1.
            if (cnt_q != '0) begin
              block_d[{byte_sel[OFF_W-1:0], 3'b000} +: 8] = bus.mem_din;
            end
            if (cnt_q == CNT_LAST) begin
              state_d     = COMMIT;
              fill_addr_d = base_q;
              cnt_d       = '0;
            end
          end
        end
      end
      COMMIT: begin
        we = 1'b1;
        if (rdy_in) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      base_q      <= '0;
      fill_addr_q <= '0;
      block_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      base_q      <= base_d;
      fill_addr_q <= fill_addr_d;
      block_q     <= block_d;
    end
  end

  assign bus.mem_req   = mem_req;
  assign bus.mem_a     = mem_a;
  assign bus.mem_wr    = 1'b0;
  assign bus.busy      = (state_q != IDLE);
  assign bus.we        = we;
  assign bus.fill_addr = fill_addr_q;
  assign bus.block     = block_q;
endmodule

// File: tb/tb_icache_filler.sv
// Scoreboard bench for icache_filler: expected addresses and fills are queued as requests are driven.
module tb_icache_filler;
  localparam int BB = 16;

  logic clk = 1'b0;
  logic rst_in;
  logic rdy_in;
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   we_cnt   = 0;
  int   exp_we   = 0;
  bit   mon_en   = 1'b0;

  typedef struct {
    logic [31:0]     addr;
    logic [8*BB-1:0] blk;
    int              cyc;
  } fill_t;

  fill_t       exp_q[$];
  logic [31:0] addr_q[$];

  icache_filler_if #(.BLOCK_BYTES(BB)) bus();

  icache_filler #(.BLOCK_BYTES(BB)) dut (
    .clk_in (clk),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM returns the low address byte one cycle later; it is frozen by the global ready like everything else.
  always @(posedge clk) if (rdy_in) bus.mem_din <= bus.mem_a[7:0];

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_addrs(input logic [31:0] addr, input int n);
    logic [31:0] base = addr & ~32'(BB - 1);
    for (int i = 0; i < n; i++) addr_q.push_back(base + ((i < BB) ? 32'(i) : 32'(BB - 1)));
  endtask

  task automatic push_fill(input logic [31:0] addr, input int t, input int stall);
    fill_t e;
    e.addr = addr & ~32'(BB - 1);
    for (int i = 0; i < BB; i++) e.blk[8*i +: 8] = 8'(e.addr + 32'(i));
    e.cyc = t + BB + 2 + stall;
    exp_q.push_back(e);
    exp_we++;
    push_addrs(addr, BB + 1);
  endtask

  task automatic end_check(input string tag);
    check({tag, "_fills_left"}, exp_q.size(), 0);
    check({tag, "_addrs_left"}, addr_q.size(), 0);
    check({tag, "_we_count"}, we_cnt, exp_we);
    check({tag, "_idle"}, bus.busy, 0);
  endtask

  task automatic run_fill(input string tag, input logic [31:0] addr, input int gnt_delay,
                          input int stall_at, input int stall_len);
    logic [31:0] base = addr & ~32'(BB - 1);
    tick();
    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    bus.mem_gnt   = 1'b0;
    for (int i = 0; i < gnt_delay; i++) begin
      @(negedge clk);
      check({tag, "_no_req_wo_gnt"}, bus.mem_req, 0);
      check({tag, "_idle_wo_gnt"}, bus.busy, 0);
      tick();
    end
    bus.mem_gnt = 1'b1;
    push_fill(addr, cyc, stall_len);
    tick();
    bus.req_valid = 1'b0;
    bus.mem_gnt   = 1'b0;
    @(negedge clk);
    check({tag, "_busy_after_accept"}, bus.busy, 1);
    if (stall_len > 0) begin
      for (int i = 0; i < stall_at; i++) tick();
      rdy_in = 1'b0;
      for (int i = 0; i < stall_len; i++) begin
        @(negedge clk);
        check({tag, "_stall_addr_hold"}, bus.mem_a, base + 32'(stall_at));
        tick();
      end
      rdy_in = 1'b1;
    end
    repeat (BB + 4) tick();
    end_check(tag);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (rdy_in && bus.mem_req) begin
        check("mem_wr", bus.mem_wr, 0);
        if (addr_q.size() == 0) check("mem_a_unexpected", 1, 0);
        else check("mem_a", bus.mem_a, addr_q.pop_front());
      end
      if (rdy_in && bus.we) begin
        we_cnt++;
        if (exp_q.size() == 0) begin
          check("we_unexpected", 1, 0);
        end else begin
          fill_t e;
          e = exp_q.pop_front();
          check("fill_addr", bus.fill_addr, e.addr);
          check("block", bus.block, e.blk);
          check("we_cycle", cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    int t;
    rst_in        = 1'b1;
    rdy_in        = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.mem_gnt   = 1'b0;
    bus.flush     = 1'b0;
    repeat (2) tick();
    rst_in = 1'b0;
    rdy_in = 1'b1;
    @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_we", bus.we, 0);
    check("rst_mem_req", bus.mem_req, 0);
    check("rst_mem_a", bus.mem_a, 0);
    check("rst_fill_addr", bus.fill_addr, 0);
    check("rst_block", bus.block, 0);
    mon_en = 1'b1;

    run_fill("basic", 32'h0000_1234, 0, 0, 0);
    check("fill_addr_hold", bus.fill_addr, 32'h0000_1230);
    check("block_hold_b0", bus.block[7:0], 8'h30);

    run_fill("stall", 32'h0000_1234, 0, 5, 3);
    run_fill("gnt_wait", 32'h0000_0ABC, 4, 0, 0);

    // Flush at cnt=7.
    tick();
    bus.req_valid = 1'b1;
    bus.mem_gnt   = 1'b1;
    bus.req_addr  = 32'h0000_2005;
`ifdef ICACHE_FILLER_ABORT_EN
    push_addrs(32'h0000_2005, 8);
`else
    push_fill(32'h0000_2005, cyc, 0);
`endif
    tick();
    bus.req_valid = 1'b0;
    bus.mem_gnt   = 1'b0;
    repeat (7) tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    @(negedge clk);
`ifdef ICACHE_FILLER_ABORT_EN
    check("flush_busy", bus.busy, 0);
    check("flush_mem_req", bus.mem_req, 0);
`else
    check("flush_ignored_busy", bus.busy, 1);
`endif
    repeat (BB + 4) tick();
    end_check("flush");

    // Reset at cnt=9 abandons the fill.
    tick();
    bus.req_valid = 1'b1;
    bus.mem_gnt   = 1'b1;
    bus.req_addr  = 32'h0000_3000;
    push_addrs(32'h0000_3000, 10);
    tick();
    bus.req_valid = 1'b0;
    bus.mem_gnt   = 1'b0;
    repeat (9) tick();
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    @(negedge clk);
    check("midrst_busy", bus.busy, 0);
    check("midrst_mem_req", bus.mem_req, 0);
    check("midrst_mem_a", bus.mem_a, 0);
    check("midrst_we", bus.we, 0);
    check("midrst_fill_addr", bus.fill_addr, 0);
    check("midrst_block", bus.block, 0);
    repeat (BB + 4) tick();
    end_check("midrst");

    run_fill("top_of_mem", 32'hFFFF_FFF0, 0, 0, 0);

    // Request held through COMMIT: second fill accepted only in the following IDLE cycle.
    tick();
    bus.req_valid = 1'b1;
    bus.mem_gnt   = 1'b1;
    bus.req_addr  = 32'h0000_4008;
    t = cyc;
    push_fill(32'h0000_4008, t, 0);
    tick();
    bus.req_addr = 32'h0000_5000;
    repeat (17) tick();
    @(negedge clk);
    check("b2b_commit_busy", bus.busy, 1);
    check("b2b_commit_cycle", cyc, t + BB + 2);
    tick();
    push_fill(32'h0000_5000, cyc, 0);
    tick();
    bus.req_valid = 1'b0;
    bus.mem_gnt   = 1'b0;
    repeat (BB + 4) tick();
    end_check("b2b");
    check("b2b_fill_addr_hold", bus.fill_addr, 32'h0000_5000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/icache_filler.md
ICACHE_FILLER -- requirements
Module: icache_filler

Interface
REQ-001 Parameter BLOCK_BYTES, default 16, bytes per cache block; power of two, 4..64.
REQ-002 clk_in  input  1  clock; all state updates on rising edge.
REQ-003 rst_in  input  1  reset; synchronous, active-high.
REQ-004 rdy_in  input  1  global ready; low freezes all state and holds all outputs.
REQ-005 req_valid  input  1  fetch unit reports an instruction-cache miss.
REQ-006 req_addr  input  32  missing instruction address.
REQ-007 mem_gnt  input  1  memory arbiter grants the RAM port to this block.
REQ-008 flush  input  1  pipeline flush (branch mispredict).
REQ-009 mem_din  input  8  RAM read data, valid one cycle after the address.
REQ-010 mem_req  output  1  RAM port in use by this block.
REQ-011 mem_a  output  32  RAM byte address.
REQ-012 mem_wr  output  1  RAM write strobe; constant 0.
REQ-013 busy  output  1  fill in progress (state not IDLE).
REQ-014 we  output  1  cache write enable; one-cycle pulse per completed fill.
REQ-015 fill_addr  output  32  block base address presented to the cache with we.
REQ-016 block  output  8*BLOCK_BYTES  assembled block; byte i at bits [8i+7:8i].

Function
REQ-017 States IDLE, FETCH, COMMIT; all transitions require rdy_in=1.
REQ-018 IDLE: req_valid=1 and mem_gnt=1 -> latch base = req_addr with low log2(BLOCK_BYTES) bits zeroed, cnt=0, go FETCH; otherwise stay.
REQ-019 FETCH: mem_req=1, mem_a = base+cnt while cnt<BLOCK_BYTES, else mem_a = base+BLOCK_BYTES-1; cnt increments each cycle.
REQ-020 FETCH with cnt>=1: mem_din captured into byte cnt-1 of block.
REQ-021 FETCH with cnt=BLOCK_BYTES: last byte captured, go COMMIT.
REQ-022 COMMIT: we=1, fill_addr=base, block stable; next state IDLE.
REQ-023 Latency: accept at cycle T -> we at cycle T+BLOCK_BYTES+2, given rdy_in=1 throughout.
REQ-024 req_valid outside IDLE ignored; no request queued; a request coincident with COMMIT is not accepted until next IDLE cycle.
REQ-025 rdy_in=0 in any state: state, cnt, block and outputs hold; captures for that cycle are skipped and the same address is re-presented next ready cycle.
REQ-026 mem_req, we low in IDLE; mem_a = 0 in IDLE and COMMIT.
REQ-027 Address arithmetic 32-bit, wraps modulo 2^32; base alignment guarantees no carry out of offset bits.
REQ-028 fill_addr and block hold their last values after COMMIT until next fill overwrites them.

Reset
REQ-029 rst_in=1 at a clock edge: state IDLE, cnt 0, base 0, block 0, fill_addr 0, we 0, mem_req 0, mem_a 0, busy 0, regardless of rdy_in.
REQ-030 Reset mid-FETCH abandons the fill; no we pulse follows.

Configuration
REQ-031 Macro ICACHE_FILLER_ABORT_EN defined: flush=1 in FETCH -> IDLE next cycle, no we pulse, mem_req drops; flush in COMMIT still yields the we pulse.
REQ-032 Macro undefined: flush ignored; every accepted fill completes with one we pulse.

Verification
REQ-033 Reset then req_valid=1, mem_gnt=1, req_addr=0x0000_1234, RAM byte k = k&0xFF -> mem_a 0x1230..0x123F on consecutive cycles, we at T+18, fill_addr=0x1230, block byte i = 0x30+i.
REQ-034 Same fill with rdy_in low for 3 cycles at cnt=5 -> addresses resume at 0x1235, block identical, we at T+21.
REQ-035 req_valid=1, mem_gnt=0 for 4 cycles then 1 -> no mem_req until grant; fill starts cycle after grant accepted.
REQ-036 ABORT_EN defined, flush at cnt=7 -> busy 0 next cycle, no we; undefined -> we still at T+18.
REQ-037 rst_in at cnt=9 -> all outputs 0 next cycle; new request at 0xFFFF_FFF0 -> mem_a 0xFFFF_FFF0..0xFFFF_FFFF, no wrap error.
REQ-038 req_valid held high through COMMIT -> second fill accepted only in following IDLE cycle, exactly one we per fill.
